// File: rtl/sccb_slave_responder.sv
// SCCB responder: camera-side register model on the far end of an SCCB bus.
// Oversamples SIO_C/SIO_D with clk, decodes start/stop, ID, sub-address and
// data phases, keeps an 8-bit register file, and pulls SIO_D low
// (open-drain) for ACK bits and read data.
module sccb_slave_responder #(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         REG_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sio_c_i,
    input  logic              sio_d_i,
    output logic              sio_d_oe,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data,
    output logic              busy
);

    localparam int DEPTH = 1 << REG_AW;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ID        = 4'd1;
    localparam logic [3:0] S_ID_ACK    = 4'd2;
    localparam logic [3:0] S_SUB       = 4'd3;
    localparam logic [3:0] S_SUB_ACK   = 4'd4;
    localparam logic [3:0] S_DATA      = 4'd5;
    localparam logic [3:0] S_DATA_ACK  = 4'd6;
    localparam logic [3:0] S_RD        = 4'd7;
    localparam logic [3:0] S_RD_NA     = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    // Line synchronisers plus one history flop per line.
    logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d;
    logic [SYNC_STAGES-1:0] d_sync_q, d_sync_d;
    logic                   c_hist_q, c_hist_d;
    logic                   d_hist_q, d_hist_d;

    // Protocol state.
    logic [3:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    // Register file and its single write port.
    logic [7:0]        regfile_q [DEPTH];
    logic              regfile_we_d;
    logic [REG_AW-1:0] regfile_waddr_d;
    logic [7:0]        regfile_wdata_d;

    logic       scl, sda;
    logic       scl_rise, scl_fall, start_evt, stop_evt;
    logic [7:0] byte_in;
    logic [7:0] rd_byte;

    assign scl = c_sync_q[SYNC_STAGES-1];
    assign sda = d_sync_q[SYNC_STAGES-1];

    // Both events need SCL high on the current and previous sample, so an
    // SDA change that races an SCL edge is never mistaken for start/stop.
    assign scl_rise  = scl & ~c_hist_q;
    assign scl_fall  = ~scl & c_hist_q;
    assign start_evt = scl & c_hist_q & ~sda & d_hist_q;
    assign stop_evt  = scl & c_hist_q & sda & ~d_hist_q;

    assign byte_in = {shift_q, sda};
    assign rd_byte = regfile_q[ptr_q];

    assign sio_d_oe  = oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign dbg_data  = regfile_q[dbg_addr];

    // Shift the raw pin levels into the synchroniser chains.
    always_comb begin
        c_sync_d = {c_sync_q[SYNC_STAGES-2:0], sio_c_i};
        d_sync_d = {d_sync_q[SYNC_STAGES-2:0], sio_d_i};
        c_hist_d = scl;
        d_hist_d = sda;
    end

    // Synchroniser flops; reset to the idle (high) bus level so that leaving
    // reset never fabricates a start or stop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            c_hist_q <= 1'b1;
            d_hist_q <= 1'b1;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            c_hist_q <= c_hist_d;
            d_hist_q <= d_hist_d;
        end
    end

    // Transaction decoder: bits are taken on SCL rise, SIO_D drive changes on
    // SCL fall. In the ACK states bit_cnt counts SCL falls: the first opens
    // the ACK window, the second closes it and enters the next phase.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rw_d            = rw_q;
        ptr_d           = ptr_q;
        oe_d            = oe_q;
        busy_d          = busy_q;
        wr_strobe_d     = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        regfile_we_d    = 1'b0;
        regfile_waddr_d = ptr_q;
        regfile_wdata_d = byte_in;

        if (start_evt) begin
            state_d   = S_ID;
            bit_cnt_d = 3'd0;
            shift_d   = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_evt) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ID: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (byte_in[7:1] == DEV_ID) begin
                                rw_d    = byte_in[0];
                                state_d = S_ID_ACK;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            oe_d      = 1'b1;
                            bit_cnt_d = 3'd1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == S_ID_ACK) begin
                                if (rw_q) begin
                                    // First read bit goes out on this same fall.
                                    state_d = S_RD;
                                    shift_d = rd_byte[6:0];
                                    oe_d    = ~rd_byte[7];
                                end else begin
                                    state_d = S_SUB;
                                end
                            end else if (state_q == S_SUB_ACK) begin
                                state_d = S_DATA;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end
                    end
                end
                S_SUB: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            ptr_d     = REG_AW'(byte_in);
                            bit_cnt_d = 3'd0;
                            state_d   = S_SUB_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            regfile_we_d = 1'b1;
                            wr_strobe_d  = 1'b1;
                            wr_addr_d    = ptr_q;
                            wr_data_d    = byte_in;
                            bit_cnt_d    = 3'd0;
                            state_d      = S_DATA_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = S_RD_NA;
                        end else begin
                            oe_d      = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_RD_NA: begin
                    // The master's NA/ACK level is irrelevant; only its clock matters.
                    if (scl_rise) begin
                        state_d = S_WAIT_STOP;
                    end
                end
                default: begin
                    // IDLE and WAIT_STOP only react to start/stop.
                end
            endcase
        end
    end

    // Decoder state flops; reset also releases SIO_D immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file: cleared by reset, written in the wr_strobe cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regfile_q[i] <= 8'h00;
            end
        end else if (regfile_we_d) begin
            regfile_q[regfile_waddr_d] <= regfile_wdata_d;
        end
    end

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Self-checking bench for sccb_slave_responder: a bit-banged SCCB master
// drives the bus, a table of directed transfers plus hand-written corner
// sequences and random transfers are checked against constants and a
// register-file/pointer model.
module tb_sccb_slave_responder;

    localparam int Q = 5;  // clk cycles per quarter SCL period (SCL = clk/20)

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sio_c_i, sio_d_i, sio_d_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    int checks = 0;
    int failures = 0;
    int strb_cnt = 0;
    int oe_cnt = 0;

    always #5 clk = ~clk;

    assign sio_c_i = m_scl;
    assign sio_d_i = m_sda & ~sio_d_oe;   // open-drain wired-AND

    sccb_slave_responder #(
        .DEV_ID(7'h21), .REG_AW(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .resetn(resetn), .sio_c_i(sio_c_i), .sio_d_i(sio_d_i),
        .sio_d_oe(sio_d_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
    );

    // Count strobe cycles and cycles where the responder pulls SIO_D.
    always @(negedge clk) begin
        if (wr_strobe) strb_cnt++;
        if (sio_d_oe) oe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] m_reg [256];
    logic [7:0] m_ptr;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
        m_ptr = 8'h00;
    endtask

    // Byte 0 of 'by' is the ID in [31:24]; n bytes are sent by the master.
    task automatic model_xfer(input logic [31:0] by, input int n,
                              output logic [3:0] acks, output logic [7:0] rdv,
                              output int strb);
        acks = 4'b0000;
        rdv  = 8'hFF;             // nobody drives: bus floats high
        strb = 0;
        if (by[31:25] == 7'h21) begin
            acks[0] = 1'b1;
            if (by[24]) begin
                rdv = m_reg[m_ptr];
            end else begin
                if (n > 1) begin m_ptr = by[23:16]; acks[1] = 1'b1; end
                if (n > 2) begin m_reg[m_ptr] = by[15:8]; acks[2] = 1'b1; strb = 1; end
            end
        end
    endtask

    // ---------------- bench helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;  wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        s = sio_d_i;  wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            v[i] = s;
        end
        bus_bit(1'b1, s);          // NA from the master
        check("na_released", {31'b0, s}, 32'd1);
    endtask

    task automatic run_xfer(input logic [31:0] by, input int n,
                            output logic [3:0] acks, output logic [7:0] rdv);
        logic a;
        acks = 4'b0000;
        rdv  = 8'h00;
        start_cond();
        for (int i = 0; i < n; i++) begin
            send_byte(by[31-8*i -: 8], a);
            acks[i] = a;
        end
        if (by[24]) recv_byte(rdv);
        stop_cond();
        $display("xfer bytes=%h n=%0d acks=%b rd=%h strobes=%0d", by, n, acks, rdv, strb_cnt);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] by;
        int          n;
        logic [3:0]  acks;
        logic [7:0]  rd;
        int          strb;
        logic [7:0]  da;
        logic [7:0]  dv;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [3:0]  acks, macks;
        logic [7:0]  rdv, mrd, id, addr, data, id_w;
        logic [31:0] by;
        logic        s, a;
        int          s0, o0, mstrb, n, kind;

        vt[0] = '{32'h420A_0000, 2, 4'b0011, 8'h00, 0, 8'h0A, 8'h5C};  // 2-phase set pointer
        vt[1] = '{32'h4300_0000, 1, 4'b0001, 8'h5C, 0, 8'h0A, 8'h5C};  // read 0x0A
        vt[2] = '{32'h600A_1100, 3, 4'b0000, 8'h00, 0, 8'h0A, 8'h5C};  // wrong ID
        vt[3] = '{32'h4205_A300, 3, 4'b0111, 8'h00, 1, 8'h05, 8'hA3};  // 3-phase write
        vt[4] = '{32'h4207_9955, 4, 4'b0111, 8'h00, 1, 8'h07, 8'h99};  // extra byte not ACKed
        vt[5] = '{32'h4300_0000, 1, 4'b0001, 8'h99, 0, 8'h07, 8'h99};  // pointer not incremented
        vt[6] = '{32'h4500_0000, 1, 4'b0000, 8'hFF, 0, 8'h05, 8'hA3};  // wrong-ID read

        model_reset();
        dbg_addr = 8'h0A;

        // ---- reset state ----
        wait_clk(4);
        check("rst_oe", {31'b0, sio_d_oe}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_strobe", {31'b0, wr_strobe}, 0);
        resetn = 1'b1;
        wait_clk(4);
        check("rst_wr_addr", {24'b0, wr_addr}, 0);
        check("rst_wr_data", {24'b0, wr_data}, 0);
        check("rst_dbg", {24'b0, dbg_data}, 0);

        // ---- 3-phase write with exact ACK window timing ----
        s0 = strb_cnt;
        id_w = 8'h42;
        start_cond();
        check("busy_after_start", {31'b0, busy}, 1);
        for (int i = 7; i >= 1; i--) bus_bit(id_w[i], s);
        m_sda = id_w[0]; wait_clk(Q);
        m_scl = 1'b1;    wait_clk(2*Q);
        m_scl = 1'b0;
        wait_clk(2); check("ack_open_early", {31'b0, sio_d_oe}, 0);
        wait_clk(1); check("ack_open", {31'b0, sio_d_oe}, 1);
        wait_clk(Q-3);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        check("id_ack_level", {31'b0, sio_d_i}, 0);
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(2); check("ack_close_early", {31'b0, sio_d_oe}, 1);
        wait_clk(1); check("ack_close", {31'b0, sio_d_oe}, 0);
        wait_clk(Q-3);
        send_byte(8'h0A, a); check("sub_ack", {31'b0, a}, 1);
        send_byte(8'h5C, a); check("data_ack", {31'b0, a}, 1);
        stop_cond();
        model_xfer(32'h420A_5C00, 3, macks, mrd, mstrb);
        $display("xfer bytes=420a5c00 n=3 (timed ACK windows) strobes=%0d", strb_cnt);
        check("w3_strobe_cnt", strb_cnt - s0, 1);
        check("w3_wr_addr", {24'b0, wr_addr}, 32'h0A);
        check("w3_wr_data", {24'b0, wr_data}, 32'h5C);
        check("w3_busy_after_stop", {31'b0, busy}, 0);
        dbg_addr = 8'h0A; wait_clk(1);
        check("w3_dbg", {24'b0, dbg_data}, 32'h5C);

        // ---- partial sub-address then stop: no effect ----
        s0 = strb_cnt;
        start_cond();
        send_byte(8'h42, a); check("partial_id_ack", {31'b0, a}, 1);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        stop_cond();
        $display("xfer bytes=42+4bits (aborted) strobes=%0d", strb_cnt);
        check("partial_strobe", strb_cnt - s0, 0);
        run_xfer(32'h4300_0000, 1, acks, rdv);
        model_xfer(32'h4300_0000, 1, macks, mrd, mstrb);
        check("partial_ptr_kept", {24'b0, rdv}, 32'h5C);

        // ---- table ----
        for (int i = 0; i < 7; i++) begin
            s0 = strb_cnt;
            o0 = oe_cnt;
            model_xfer(vt[i].by, vt[i].n, macks, mrd, mstrb);
            run_xfer(vt[i].by, vt[i].n, acks, rdv);
            check("tbl_acks", {28'b0, acks}, {28'b0, vt[i].acks});
            if (vt[i].by[24]) check("tbl_rd", {24'b0, rdv}, {24'b0, vt[i].rd});
            check("tbl_strobe", strb_cnt - s0, vt[i].strb);
            if (vt[i].strb != 0) begin
                check("tbl_wr_addr", {24'b0, wr_addr}, {24'b0, vt[i].by[23:16]});
                check("tbl_wr_data", {24'b0, wr_data}, {24'b0, vt[i].by[15:8]});
            end
            if (vt[i].acks == 4'b0000) check("tbl_oe_silent", oe_cnt - o0, 0);
            check("tbl_oe_after_stop", {31'b0, sio_d_oe}, 0);
            check("tbl_busy_after_stop", {31'b0, busy}, 0);
            dbg_addr = vt[i].da; wait_clk(1);
            check("tbl_dbg", {24'b0, dbg_data}, {24'b0, vt[i].dv});
        end

        // ---- repeated start: write pointer, Sr, read ----
        s0 = strb_cnt;
        start_cond();
        send_byte(8'h42, a); check("rs_id_ack", {31'b0, a}, 1);
        send_byte(8'h0A, a); check("rs_sub_ack", {31'b0, a}, 1);
        check("rs_busy_before_sr", {31'b0, busy}, 1);
        start_cond();
        check("rs_busy_after_sr", {31'b0, busy}, 1);
        send_byte(8'h43, a); check("rs_rd_ack", {31'b0, a}, 1);
        recv_byte(rdv);
        check("rs_busy_before_stop", {31'b0, busy}, 1);
        stop_cond();
        model_xfer(32'h420A_0000, 2, macks, mrd, mstrb);
        $display("xfer bytes=42 0a Sr 43 rd=%h", rdv);
        check("rs_rd_data", {24'b0, rdv}, 32'h5C);
        check("rs_busy_after_stop", {31'b0, busy}, 0);
        check("rs_strobe", strb_cnt - s0, 0);

        // ---- randomized transfers against the model ----
        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(0, 4));
            addr = 8'($urandom_range(0, 15));
            data = 8'($urandom);
            n = 1;
            by = 32'h0;
            case (kind)
                0: begin by = {8'h42, addr, data, 8'h00}; n = 3; end
                1: begin by = {8'h42, addr, 16'h0000}; n = 2; end
                2: begin by = {8'h43, 24'h000000}; n = 1; end
                3: begin
                    id = 8'($urandom);
                    if (id[7:1] == 7'h21) id[7] = ~id[7];
                    by = {id, addr, data, 8'h00};
                    n = int'($urandom_range(1, 3));
                end
                default: begin by = {8'h42, addr, data, 8'h77}; n = 4; end
            endcase
            s0 = strb_cnt;
            model_xfer(by, n, macks, mrd, mstrb);
            run_xfer(by, n, acks, rdv);
            check("rnd_acks", {28'b0, acks}, {28'b0, macks});
            if (by[24]) check("rnd_rd", {24'b0, rdv}, {24'b0, mrd});
            check("rnd_strobe", strb_cnt - s0, mstrb);
            if (mstrb != 0) begin
                check("rnd_wr_addr", {24'b0, wr_addr}, {24'b0, by[23:16]});
                check("rnd_wr_data", {24'b0, wr_data}, {24'b0, by[15:8]});
            end
            dbg_addr = 8'($urandom_range(0, 15)); wait_clk(1);
            check("rnd_dbg", {24'b0, dbg_data}, {24'b0, m_reg[dbg_addr]});
        end

        // ---- reset in the middle of a read byte ----
        run_xfer(32'h420A_5C00, 3, acks, rdv);
        model_xfer(32'h420A_5C00, 3, macks, mrd, mstrb);
        check("pre_rst_acks", {28'b0, acks}, 32'b0111);
        start_cond();
        send_byte(8'h43, a); check("pre_rst_rd_ack", {31'b0, a}, 1);
        check("rd_msb_driven", {31'b0, sio_d_oe}, 1);   // 0x5C MSB is 0
        resetn = 1'b0;
        #1;
        check("rst_async_oe", {31'b0, sio_d_oe}, 0);
        check("rst_async_busy", {31'b0, busy}, 0);
        dbg_addr = 8'h0A; #1;
        check("rst_clear_0a", {24'b0, dbg_data}, 0);
        dbg_addr = 8'h05; #1;
        check("rst_clear_05", {24'b0, dbg_data}, 0);
        m_sda = 1'b1;
        m_scl = 1'b1;
        wait_clk(4);
        resetn = 1'b1;
        model_reset();
        wait_clk(4);
        $display("xfer reset asserted during read byte");
        run_xfer(32'h420A_0000, 2, acks, rdv);
        model_xfer(32'h420A_0000, 2, macks, mrd, mstrb);
        check("post_rst_ptr_acks", {28'b0, acks}, 32'b0011);
        run_xfer(32'h4300_0000, 1, acks, rdv);
        model_xfer(32'h4300_0000, 1, macks, mrd, mstrb);
        check("post_rst_rd", {24'b0, rdv}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_slave_responder.md
Name: sccb_slave_responder

Overview:
SCCB responder (camera-side register model) at the far end of the SCCB master's SIO_C/SIO_D bus. It oversamples both lines with the system clock, decodes start/stop and the device ID, sub-address and data phases, and maintains an internal 8-bit register file. It drives SIO_D open-drain for ACK and read data. Used as the bench/FPGA target for the SCCB master and APB wrapper.

Parameters:
DEV_ID, 7'h21, 7-bit device address; the write ID byte is 0x42 and the read ID byte is 0x43.
REG_AW, 8, register file address width; depth is 2**REG_AW.
SYNC_STAGES, 2, synchroniser depth for sio_c_i and sio_d_i (minimum 2).

Ports:
clk  input  1  system clock; must run at ≥ 16x the SIO_C rate.
resetn  input  1  asynchronous active-low reset.
sio_c_i  input  1  SIO_C pin level.
sio_d_i  input  1  SIO_D pin level (resolved bus).
sio_d_oe  output  1  1 = pull SIO_D low, 0 = release (open-drain enable).
wr_strobe  output  1  one-cycle pulse when a register is written.
wr_addr  output  REG_AW  address of the last write.
wr_data  output  8  data of the last write.
dbg_addr  input  REG_AW  backdoor read address.
dbg_data  output  8  combinational regfile[dbg_addr].
busy  output  1  high from start detect to stop detect.

Behaviour:
- Reset and clocking: reset is asynchronous, active-low on resetn; clock is clk.
- Reset values: sio_d_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, pointer=0, state=IDLE, every register=8'h00.
- Reset mid-operation releases sio_d_oe asynchronously.
- Line synchronisation: SYNC_STAGES flops per line, plus one history flop for edge detection. All decisions use the synchronised levels.
- Bus events:
  - Start = SDA falling while SCL high.
  - Stop = SDA rising while SCL high.
  - Bits are sampled on the synchronised SCL rising edge.
  - sio_d_oe is updated on the synchronised SCL falling edge, registered, so it changes SYNC_STAGES+1 clk after the pin edge.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD, RD_NA, WAIT_STOP.
  - A start in any state goes to ID with the bit counter cleared; this covers repeated start.
  - A stop in any state goes to IDLE, sets sio_d_oe=0 and busy=0.
- ID: shift 8 bits, MSB first.
  - If bits[7:1] == DEV_ID, go to ID_ACK and latch the R/W bit.
  - Otherwise go to WAIT_STOP; sio_d_oe stays 0 for the rest of the transaction.
- ACK bit timing (ID_ACK, SUB_ACK, DATA_ACK): sio_d_oe=1 from the SCL falling edge after bit 8 until the SCL falling edge after bit 9.
- After ID_ACK:
  - Write: go to SUB.
  - Read: go to RD.
- SUB: shift 8 bits, load pointer, then SUB_ACK, then DATA.
  - A stop after SUB_ACK (2-phase write) only sets the pointer.
- DATA: shift 8 bits.
  - On the SCL rising edge sampling bit 0, the next clk writes regfile[pointer]. That same cycle pulses wr_strobe, updates wr_addr/wr_data, and moves to DATA_ACK.
  - After DATA_ACK go to WAIT_STOP: no auto-increment; extra bytes are not ACKed and not written.
- RD: on the falling edge after the read ACK, drive regfile[pointer] MSB first.
  - sio_d_oe = ~bit, updated on each SCL falling edge.
  - After 8 bits, release sio_d_oe and go to RD_NA.
- RD_NA: sample the master's NA bit (value ignored), then go to WAIT_STOP. The pointer is unchanged.
- Partial byte: a start or stop before 8 bits discards the shift register; no write, pointer unchanged.
- Writes take effect in the register file on the same clk as wr_strobe. A dbg_data read of that address shows the new value from the next clk.

Test Plan:
1. 3-phase write: IDs 0x42, sub 0x0A, data 0x5C, stop → three ACK windows with sio_d_oe=1; wr_strobe pulses once with wr_addr=0x0A, wr_data=0x5C; dbg_addr=0x0A then reads 0x5C.
2. 2-phase write 0x42, 0x0A, stop; then 2-phase read 0x43, NA, stop → slave drives 0x5C MSB first on SIO_D; sio_d_oe=0 during NA and after stop; no wr_strobe.
3. Wrong ID 0x60, 0x0A, 0x11 → sio_d_oe stays 0 throughout; no wr_strobe; regfile[0x0A] unchanged.
4. Stop after 4 bits of the sub-address, then full write 0x42, 0x05, 0xA3 → first transaction has no effect; second writes regfile[0x05]=0xA3.
5. Repeated start: 0x42, 0x0A, repeated start, 0x43 → reads the register at 0x0A; busy stays high until the final stop.
6. Assert resetn=0 during the RD byte while sio_d_oe=1 → sio_d_oe=0 immediately, all registers=0x00; post-reset read of 0x0A returns 0x00.
